// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto one waitrequest-style memory master.
// Define ARB_ROUND_ROBIN_EN to alternate grants instead of data-first.
module mem_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_read,
   input  logic [ADDR_W-1:0] instr_address,
   output logic [DATA_W-1:0] instr_readdata,
   output logic              instr_waitrequest,
   input  logic              data_read,
   input  logic              data_write,
   input  logic [ADDR_W-1:0] data_address,
   input  logic [DATA_W-1:0] data_writedata,
   input  logic [3:0]        data_byteenable,
   output logic [DATA_W-1:0] data_readdata,
   output logic              data_waitrequest,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic [3:0]        mem_byteenable,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_waitrequest
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   typedef enum logic {INSTR = 1'b0, DATA = 1'b1} port_t;

   state_t state, state_nx;
   port_t  owner, grant;
   logic   data_req, any_req, grant_en, done;

   assign data_req = data_read | data_write;
   assign any_req  = instr_read | data_req;
   assign grant_en = (state == IDLE) && any_req;
   assign done     = (state == BUSY) && !mem_waitrequest;

`ifdef ARB_ROUND_ROBIN_EN
   port_t last_owner;

   always_comb begin
      grant = INSTR;
      if (data_req && instr_read)
         grant = (last_owner == INSTR) ? DATA : INSTR;
      else if (data_req)
         grant = DATA;
   end

   always_ff @(posedge clk) begin
      if (reset)
         last_owner <= INSTR;
      else if (grant_en)
         last_owner <= grant;
   end
`else
   always_comb begin
      grant = data_req ? DATA : INSTR;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (any_req) state_nx = BUSY;
         BUSY:    if (!mem_waitrequest) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner          <= INSTR;
         mem_address    <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= 4'h0;
         instr_readdata <= '0;
         data_readdata  <= '0;
      end else begin
         if (grant_en) begin
            owner <= grant;
            if (grant == DATA) begin
               // a simultaneous read+write is serviced as a write
               mem_address    <= data_address;
               mem_read       <= data_read & ~data_write;
               mem_write      <= data_write;
               mem_writedata  <= data_writedata;
               mem_byteenable <= data_write ? data_byteenable : 4'hF;
            end else begin
               mem_address    <= instr_address;
               mem_read       <= 1'b1;
               mem_write      <= 1'b0;
               mem_writedata  <= '0;
               mem_byteenable <= 4'hF;
            end
         end
         if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            // an abandoned request leaves the readdata register untouched
            if (mem_read && owner == INSTR && instr_read)
               instr_readdata <= mem_readdata;
            if (mem_read && owner == DATA && data_read && !data_write)
               data_readdata <= mem_readdata;
         end
      end
   end

   assign instr_waitrequest = !(state == RESP && owner == INSTR);
   assign data_waitrequest  = !(state == RESP && owner == DATA);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-level model,
// plus directed cases with hand-computed literal expectations.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_read = 1'b0;
   logic [31:0] instr_address = '0;
   logic [31:0] instr_readdata;
   logic        instr_waitrequest;
   logic        data_read = 1'b0;
   logic        data_write = 1'b0;
   logic [31:0] data_address = '0;
   logic [31:0] data_writedata = '0;
   logic [3:0]  data_byteenable = '0;
   logic [31:0] data_readdata;
   logic        data_waitrequest;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_readdata;
   logic        mem_waitrequest = 1'b0;

   int total = 0;
   int bad = 0;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic [31:0] mem_arr [64];

   mem_port_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .instr_read(instr_read), .instr_address(instr_address),
      .instr_readdata(instr_readdata),
      .instr_waitrequest(instr_waitrequest),
      .data_read(data_read), .data_write(data_write),
      .data_address(data_address), .data_writedata(data_writedata),
      .data_byteenable(data_byteenable),
      .data_readdata(data_readdata),
      .data_waitrequest(data_waitrequest),
      .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata),
      .mem_waitrequest(mem_waitrequest)
   );

   always #5 clk = ~clk;

   assign mem_readdata = mem_arr[mem_address[7:2]];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // transaction-level model: one access in flight, phase 0/1/2 =
   // waiting for a grant / on the memory bus / answering the owner
   bit          m_ok = 1'b0;
   int          ph = 0;
   bit          own = 1'b0;
   bit          last = 1'b0;
   logic [31:0] e_addr, e_wd, e_ird, e_drd;
   logic [3:0]  e_be;
   bit          e_rd, e_wr;
   bit          e_iw = 1'b1;
   bit          e_dw = 1'b1;

   always @(negedge clk) begin
      bit dq, w;
      int ix;
      if (m_ok) begin
         check("mem_read", {31'b0, mem_read}, {31'b0, e_rd});
         check("mem_write", {31'b0, mem_write}, {31'b0, e_wr});
         check("mem_address", mem_address, e_addr);
         check("mem_writedata", mem_writedata, e_wd);
         check("mem_byteenable", {28'b0, mem_byteenable}, {28'b0, e_be});
         check("instr_wait", {31'b0, instr_waitrequest}, {31'b0, e_iw});
         check("data_wait", {31'b0, data_waitrequest}, {31'b0, e_dw});
         check("instr_readdata", instr_readdata, e_ird);
         check("data_readdata", data_readdata, e_drd);
      end
      if (reset) begin
         ph = 0; own = 0; last = 0;
         e_addr = 0; e_wd = 0; e_be = 0; e_rd = 0; e_wr = 0;
         e_ird = 0; e_drd = 0;
         m_ok = 1'b1;
      end else if (m_ok) begin
         if (ph == 0) begin
            dq = data_read | data_write;
            if (dq || instr_read) begin
               if (dq && instr_read) w = RR ? !last : 1'b1;
               else w = dq;
               own = w; last = w; ph = 1;
               if (w) begin
                  e_addr = data_address;
                  e_wr = data_write;
                  e_rd = data_read && !data_write;
                  e_wd = data_writedata;
                  e_be = data_write ? data_byteenable : 4'hF;
               end else begin
                  e_addr = instr_address;
                  e_rd = 1; e_wr = 0; e_wd = 0; e_be = 4'hF;
               end
            end
         end else if (ph == 1) begin
            if (!mem_waitrequest) begin
               ix = int'(e_addr[7:2]);
               if (e_rd && !own) e_ird = mem_arr[ix];
               if (e_rd && own) e_drd = mem_arr[ix];
               if (e_wr)
                  for (int b = 0; b < 4; b++)
                     if (e_be[b]) mem_arr[ix][8*b +: 8] = e_wd[8*b +: 8];
               e_rd = 0; e_wr = 0; ph = 2;
            end
         end else begin
            ph = 0;
         end
      end
      e_iw = !(ph == 2 && !own);
      e_dw = !(ph == 2 && own);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nrd, nresp, rc, nd, ni, k;
      bit ok;
      logic [31:0] seq;
      for (int i = 0; i < 64; i++) mem_arr[i] = 32'h1111_1111 * (i % 8);
      mem_arr[0] = 32'h8C22_0000;
      repeat (3) tick();
      reset = 0;
      tick();

      // fetch, zero-wait memory
      instr_read = 1; instr_address = 0;
      tick();
      check("t1 mem_read", {31'b0, mem_read}, 32'd1);
      check("t1 mem_address", mem_address, 32'd0);
      tick();
      check("t1 instr_wait", {31'b0, instr_waitrequest}, 32'd0);
      check("t1 instr_readdata", instr_readdata, 32'h8C22_0000);
      instr_read = 0;
      tick();

      // store with partial lanes
      data_write = 1; data_address = 4;
      data_writedata = 32'hDEAD_BEEF; data_byteenable = 4'b0011;
      tick();
      check("t2 mem_write", {31'b0, mem_write}, 32'd1);
      check("t2 mem_read", {31'b0, mem_read}, 32'd0);
      check("t2 mem_byteenable", {28'b0, mem_byteenable}, 32'd3);
      tick();
      check("t2 data_wait", {31'b0, data_waitrequest}, 32'd0);
      check("t2 mem_write off", {31'b0, mem_write}, 32'd0);
      check("t2 data_readdata", data_readdata, 32'd0);
      data_write = 0;
      tick();

      // read+write together behaves as a write
      data_read = 1; data_write = 1; data_address = 8;
      data_writedata = 32'h1234_5678; data_byteenable = 4'hF;
      tick();
      check("t6 mem_write", {31'b0, mem_write}, 32'd1);
      check("t6 mem_read", {31'b0, mem_read}, 32'd0);
      tick();
      check("t6 data_wait", {31'b0, data_waitrequest}, 32'd0);
      check("t6 data_readdata", data_readdata, 32'd0);
      data_read = 0; data_write = 0;
      tick();

      // load with three memory stall cycles
      data_read = 1; data_address = 4;
      nrd = 0; nresp = 0; rc = 0;
      for (int c = 1; c <= 7; c++) begin
         tick();
         if (mem_read) begin
            nrd++;
            check("t4 addr stable", mem_address, 32'd4);
         end
         if (!data_waitrequest) begin
            nresp++; rc = c; data_read = 0;
         end
         if (c == 1) mem_waitrequest = 1;
         if (c == 4) mem_waitrequest = 0;
      end
      check("t4 mem_read cycles", nrd, 32'd4);
      check("t4 resp count", nresp, 32'd1);
      check("t4 resp cycle", rc, 32'd5);
      check("t4 data_readdata", data_readdata, 32'h1111_BEEF);

      // reset in the middle of an access
      data_read = 1; data_address = 0; mem_waitrequest = 1;
      tick();
      reset = 1;
      tick();
      check("t5 mem_read", {31'b0, mem_read}, 32'd0);
      check("t5 instr_wait", {31'b0, instr_waitrequest}, 32'd1);
      check("t5 data_wait", {31'b0, data_waitrequest}, 32'd1);
      check("t5 instr_readdata", instr_readdata, 32'd0);
      check("t5 data_readdata", data_readdata, 32'd0);
      reset = 0; data_read = 0; mem_waitrequest = 0;
      tick();

      // both ports requesting continuously
      instr_read = 1; instr_address = 32'h10;
      data_read = 1; data_address = 32'h20;
      nd = 0; ni = 0; k = 0; seq = '0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (!data_waitrequest) begin
            nd++; seq[k] = 1'b1; k++;
         end
         if (!instr_waitrequest) begin
            ni++; k++;
         end
      end
      instr_read = 0; data_read = 0;
      if (RR) begin
         check("t3 rr data grants", nd, 32'd5);
         check("t3 rr instr grants", ni, 32'd5);
         ok = 1;
         for (int j = 0; j < 10; j++) if (seq[j] != (j % 2 == 0)) ok = 0;
         check("t3 rr order", {31'b0, ok}, 32'd1);
      end else begin
         check("t3 data grants", nd, 32'd10);
         check("t3 instr grants", ni, 32'd0);
      end
      repeat (2) tick();

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         reset = 0;
         mem_waitrequest = ($urandom_range(3) == 0);
         if (instr_read && !e_iw) instr_read = 0;
         if ((data_read || data_write) && !e_dw) begin
            data_read = 0; data_write = 0;
         end
         if (!instr_read && $urandom_range(2) == 0) begin
            instr_read = 1;
            instr_address = {24'b0, 6'($urandom_range(63)), 2'b00};
         end
         if (!data_read && !data_write && $urandom_range(2) == 0) begin
            k = $urandom_range(2);
            data_read = (k != 1);
            data_write = (k != 0);
            data_address = {24'b0, 6'($urandom_range(63)), 2'b00};
            data_writedata = $urandom;
            data_byteenable = 4'($urandom_range(15));
         end
         if ($urandom_range(299) == 0) begin
            reset = 1;
            instr_read = 0; data_read = 0; data_write = 0;
         end
      end
      reset = 0; instr_read = 0; data_read = 0; data_write = 0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
